// File: rtl/multicycle_datapath.sv
// Multi-cycle datapath: FETCH/EXEC/WB sequencing over a request/ready fetch handshake,
// internal ALU, register file, PC, WWD output register, retired-instruction count and halt.
module multicycle_datapath #(
    parameter int unsigned          WORD_SIZE     = 16,
    parameter int unsigned          REG_ADDR_BITS = 2,
    parameter logic [WORD_SIZE-1:0] RESET_PC      = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 i_readM,
    output logic [WORD_SIZE-1:0] i_address,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 inputReady,
    output logic [WORD_SIZE-1:0] output_port,
    output logic [WORD_SIZE-1:0] num_inst,
    output logic                 is_halted
);
    localparam int unsigned          NumRegs = 1 << REG_ADDR_BITS;
    localparam logic [WORD_SIZE-1:0] One     = WORD_SIZE'(1);

    typedef enum logic [1:0] {StFetch, StExec, StWb, StHalt} state_e;

    state_e                 state_q, state_d;
    logic [WORD_SIZE-1:0]   pc_q, pc_d;
    logic [WORD_SIZE-1:0]   ir_q, ir_d;
    logic [WORD_SIZE-1:0]   alu_q, alu_d;
    logic [WORD_SIZE-1:0]   out_q, out_d;
    logic [WORD_SIZE-1:0]   cnt_q, cnt_d;
    logic [WORD_SIZE-1:0]   rf_q [NumRegs];

    logic                     rf_we;
    logic [REG_ADDR_BITS-1:0] rf_waddr;

    logic [3:0]               opcode;
    logic [5:0]               func;
    logic [REG_ADDR_BITS-1:0] rs_addr, rt_addr, rd_addr;
    logic [WORD_SIZE-1:0]     rs_val, rt_val;
    logic [WORD_SIZE-1:0]     imm_sext, imm_zext, imm_lhi;
    logic                     is_rtype, is_alu_r, is_imm, is_wwd, is_hlt, is_jmp;
    logic [WORD_SIZE-1:0]     alu_res;

    assign opcode   = ir_q[15:12];
    assign func     = ir_q[5:0];
    assign rs_addr  = ir_q[10 +: REG_ADDR_BITS];
    assign rt_addr  = ir_q[8 +: REG_ADDR_BITS];
    assign rd_addr  = ir_q[6 +: REG_ADDR_BITS];
    assign rs_val   = rf_q[rs_addr];
    assign rt_val   = rf_q[rt_addr];
    assign imm_sext = WORD_SIZE'($signed(ir_q[7:0]));
    assign imm_zext = WORD_SIZE'(ir_q[7:0]);
    assign imm_lhi  = WORD_SIZE'({ir_q[7:0], 8'h00});

    assign is_rtype = (opcode == 4'hF);
    assign is_alu_r = is_rtype && (func < 6'd8);
    assign is_wwd   = is_rtype && (func == 6'd28);
    assign is_hlt   = is_rtype && (func == 6'd29);
    assign is_imm   = (opcode == 4'h4) || (opcode == 4'h5) || (opcode == 4'h6);
    assign is_jmp   = (opcode == 4'h9);

    always_comb begin
        alu_res = '0;
        if (is_rtype) begin
            unique case (func)
                6'd0:    alu_res = rs_val + rt_val;
                6'd1:    alu_res = rs_val - rt_val;
                6'd2:    alu_res = rs_val & rt_val;
                6'd3:    alu_res = rs_val | rt_val;
                6'd4:    alu_res = ~rs_val;
                6'd5:    alu_res = '0 - rs_val;
                6'd6:    alu_res = {rs_val[WORD_SIZE-2:0], 1'b0};
                6'd7:    alu_res = {rs_val[WORD_SIZE-1], rs_val[WORD_SIZE-1:1]};
                6'd28:   alu_res = rs_val;  // WWD operand carried to WB
                default: alu_res = '0;
            endcase
        end else begin
            unique case (opcode)
                4'h4:    alu_res = rs_val + imm_sext;
                4'h5:    alu_res = rs_val | imm_zext;
                4'h6:    alu_res = imm_lhi;
                default: alu_res = '0;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        alu_d    = alu_q;
        out_d    = out_q;
        cnt_d    = cnt_q;
        rf_we    = 1'b0;
        rf_waddr = is_rtype ? rd_addr : rt_addr;
        unique case (state_q)
            StFetch: begin
                if (inputReady) begin
                    ir_d    = i_data;
                    state_d = StExec;
                end
            end
            StExec: begin
                alu_d   = alu_res;
                state_d = StWb;
            end
            StWb: begin
                rf_we   = is_alu_r || is_imm;
                pc_d    = is_jmp ? {pc_q[WORD_SIZE-1:12], ir_q[11:0]} : pc_q + One;
                cnt_d   = cnt_q + One;
                if (is_wwd) out_d = alu_q;
                state_d = is_hlt ? StHalt : StFetch;
            end
            StHalt: state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            alu_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < NumRegs; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            alu_q   <= alu_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            if (rf_we) rf_q[rf_waddr] <= alu_q;
        end
    end

    // Request is suppressed while reset is held even though the state reads FETCH.
    assign i_readM     = (state_q == StFetch) && reset_n;
    assign i_address   = pc_q;
    assign output_port = out_q;
    assign num_inst    = cnt_q;
    assign is_halted   = (state_q == StHalt);
endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench: instruction-level reference model driven by a randomised memory.
module tb_multicycle_datapath;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_readM;
    logic [15:0] i_address;
    logic [15:0] i_data = '0;
    logic        inputReady = 1'b0;
    logic [15:0] output_port;
    logic [15:0] num_inst;
    logic        is_halted;

    always #5 clk = ~clk;

    multicycle_datapath #(
        .WORD_SIZE    (16),
        .REG_ADDR_BITS(2),
        .RESET_PC     (16'h0000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_readM    (i_readM),
        .i_address  (i_address),
        .i_data     (i_data),
        .inputReady (inputReady),
        .output_port(output_port),
        .num_inst   (num_inst),
        .is_halted  (is_halted)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [4096];
    logic [15:0] m_rf [4];
    logic [15:0] m_pc, m_cnt, m_out, m_ir;
    bit          m_halted;
    int          busy;
    bit          always_rdy;
    int          force_wait;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000;
        m_cnt = '0;
        m_out = '0;
        m_ir = '0;
        m_halted = 1'b0;
        busy = 0;
        for (int i = 0; i < 4; i++) m_rf[i] = '0;
    endtask

    task automatic model_exec(input logic [15:0] ir);
        logic [15:0] a, b, imm8;
        int op, f;
        bit jumped;
        op = int'(ir[15:12]);
        f = int'(ir[5:0]);
        a = m_rf[ir[11:10]];
        b = m_rf[ir[9:8]];
        imm8 = {8'h00, ir[7:0]};
        jumped = 1'b0;
        if (op == 15) begin
            case (f)
                0: m_rf[ir[7:6]] = a + b;
                1: m_rf[ir[7:6]] = a - b;
                2: m_rf[ir[7:6]] = a & b;
                3: m_rf[ir[7:6]] = a | b;
                4: m_rf[ir[7:6]] = ~a;
                5: m_rf[ir[7:6]] = 16'h0000 - a;
                6: m_rf[ir[7:6]] = a << 1;
                7: m_rf[ir[7:6]] = (a >> 1) | (a & 16'h8000);
                28: m_out = a;
                29: m_halted = 1'b1;
                default: ;
            endcase
        end else if (op == 4) begin
            m_rf[ir[9:8]] = a + (ir[7] ? (imm8 | 16'hFF00) : imm8);
        end else if (op == 5) begin
            m_rf[ir[9:8]] = a | imm8;
        end else if (op == 6) begin
            m_rf[ir[9:8]] = imm8 << 8;
        end else if (op == 9) begin
            m_pc = {m_pc[15:12], ir[11:0]};
            jumped = 1'b1;
        end
        if (!jumped) m_pc = m_pc + 16'd1;
        m_cnt = m_cnt + 16'd1;
    endtask

    function automatic logic [15:0] gen_instr();
        logic [15:0] r;
        logic [3:0]  junk_op [8];
        int k;
        junk_op = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'h8, 4'hA, 4'hB};
        r = 16'($urandom);
        k = int'($urandom_range(0, 99));
        if (k < 45)      return {4'hF, r[11:6], 3'b000, r[2:0]};
        else if (k < 60) return {4'hF, r[11:10], 4'b0000, 6'd28};
        else if (k < 85) return {4'(4 + k % 3), r[11:0]};
        else if (k < 89) return {4'h9, r[11:0]};
        else if (k < 90) return 16'hF01D;
        else if (r[15])  return {4'hF, r[11:6], 6'd30 + {1'b0, r[4:0]}};
        else             return {junk_op[r[14:12]], r[11:0]};
    endfunction

    // One clock: checks at the falling edge, then drives inputs for the next rising edge.
    task automatic step();
        bit rdy;
        @(negedge clk);
        if (m_halted) begin
            check("halted", {15'b0, is_halted}, 16'd1);
            check("halt_readM", {15'b0, i_readM}, 16'd0);
            check("halt_pc", i_address, m_pc);
            check("halt_cnt", num_inst, m_cnt);
            inputReady = 1'($urandom_range(0, 1));
            i_data = 16'($urandom);
        end else if (busy == 0) begin
            check("fetch_readM", {15'b0, i_readM}, 16'd1);
            check("fetch_addr", i_address, m_pc);
            check("num_inst", num_inst, m_cnt);
            check("output_port", output_port, m_out);
            check("not_halted", {15'b0, is_halted}, 16'd0);
            if (force_wait > 0) begin
                rdy = 1'b0;
                force_wait--;
            end else begin
                rdy = always_rdy || ($urandom_range(0, 2) != 0);
            end
            inputReady = rdy;
            i_data = mem[m_pc[11:0]];
            if (rdy) begin
                m_ir = mem[m_pc[11:0]];
                busy = 2;
            end
        end else begin
            check("busy_readM", {15'b0, i_readM}, 16'd0);
            check("busy_cnt", num_inst, m_cnt);
            inputReady = 1'($urandom_range(0, 1));
            i_data = 16'($urandom);
            busy--;
            if (busy == 0) model_exec(m_ir);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        inputReady = 1'b0;
        #1;
        check("rst_readM", {15'b0, i_readM}, 16'd0);
        check("rst_pc", i_address, 16'h0000);
        check("rst_cnt", num_inst, 16'd0);
        check("rst_out", output_port, 16'd0);
        check("rst_halt", {15'b0, is_halted}, 16'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic run_until_halt(input int budget);
        for (int c = 0; c < budget && !m_halted; c++) step();
        repeat (5) step();
        check("halt_reached", {15'b0, is_halted}, 16'd1);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    endtask

    initial begin
        force_wait = 0;
        always_rdy = 1'b1;
        model_reset();

        // ADI r1,r0,-1; ADD r2,r1,r1; WWD r2; HLT
        clear_mem();
        mem[0] = 16'h41FF; mem[1] = 16'hF580; mem[2] = 16'hF81C; mem[3] = 16'hF01D;
        do_reset();
        repeat (10) step();
        check("lat9_cnt", num_inst, 16'd3);
        run_until_halt(100);
        check("add_out", output_port, 16'hFFFE);

        // LHI r3,0x5A; ORI r3,r3,0xA5; WWD r3; HLT
        clear_mem();
        mem[0] = 16'h635A; mem[1] = 16'h5FA5; mem[2] = 16'hFC1C; mem[3] = 16'hF01D;
        do_reset();
        run_until_halt(100);
        check("lhi_ori_out", output_port, 16'h5AA5);

        // Four stalled fetch cycles, then NOPs and JMP 0x010 at PC 5
        clear_mem();
        mem[5] = 16'h9010; mem[16'h10] = 16'hF01D;
        do_reset();
        force_wait = 4;
        repeat (8) step();
        check("wait_retire", num_inst, 16'd1);
        run_until_halt(200);
        check("jmp_cnt", num_inst, 16'd7);
        check("jmp_pc", i_address, 16'h0011);

        // Reset while the second ADI sits in EXEC; registers must come back cleared
        clear_mem();
        mem[0] = 16'h4105; mem[1] = 16'h4107;
        do_reset();
        repeat (4) step();
        do_reset();
        mem[0] = 16'h4603; mem[1] = 16'hF81C; mem[2] = 16'hF01D;
        run_until_halt(100);
        check("rst_mid_out", output_port, 16'h0003);

        // Random programs with random memory wait states
        always_rdy = 1'b0;
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 4096; i++) mem[i] = gen_instr();
            do_reset();
            repeat (600) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
